spi_eeprom_responder: RTL and testbench
=======================================

Name: spi_eeprom_responder

Overview:
- Synthesizable SPI slave (mode 0, MSB first) that emulates the M95xxx EEPROM command subset at the far end of axi2spi_bridge's SPI port.
- Lets the bridge be exercised in RTL and FPGA loopback without the behavioural EEPROM model.
- SCLK, SS_n and MOSI are oversampled in the FCLK_CLK0 domain; there is no second clock.
- Implements WREN, WRDI, RDSR, READ and WRITE over a small register-array memory.

Parameters:
- ADDR_BITS, 4, memory index width; depth is 2**ADDR_BITS bytes. Only the low ADDR_BITS bits of the address byte are used.
- SYNC_STAGES, 2, synchronizer flops on i_sclk, i_ss_n and i_mosi; legal values are 2 or 3.

Ports:
- FCLK_CLK0  in  1  system clock.
- RST_N  in  1  reset, synchronous, active-low.
- i_sclk  in  1  SPI clock from master; idles low (CPOL=0).
- i_ss_n  in  1  slave select, active-low.
- i_mosi  in  1  master-out data.
- o_miso  out  1  slave-out data.
- o_miso_oe  out  1  high while the slave drives MISO.
- o_wel  out  1  write-enable latch.
- o_rx_valid  out  1  one-cycle pulse per complete received byte.
- o_rx_byte  out  8  last complete received byte; valid when o_rx_valid is high.

Behaviour:
- Clock/reset: one clock, FCLK_CLK0. RST_N is synchronous and active-low.
- Reset values: o_miso=0, o_miso_oe=0, o_wel=0, o_rx_valid=0, o_rx_byte=0x00, FSM=IDLE, bit counter=0, memory all 0x00. Reset mid-transfer aborts the transfer with no memory write.
- Input conditioning: inputs pass through SYNC_STAGES flops. Edge detect on the synchronized SCLK gives rise_p and fall_p. Requirement: SCLK high and low phases each ≥4 FCLK_CLK0 cycles.
- Receive: on rise_p with SS active, shift the MOSI sample into rx_sr (MSB first) and increment the 3-bit counter. When the counter wraps to 0, the byte is complete: o_rx_byte <= byte and o_rx_valid pulses one cycle later.
- Transmit: on fall_p, if the counter is 0, load tx_sr with the next byte, else shift tx_sr left. o_miso = tx_sr[7] while o_miso_oe=1, else 0.
- SS deassert (synchronized rising): FSM returns to IDLE, the counter clears, any partial byte is discarded, and o_miso_oe drops within 1 cycle. If the completed op was a WRITE with ≥1 data byte committed, o_wel clears.
- FSM states: IDLE, CMD, ADDR, WR_DATA, RD_DATA, RDSR, IGNORE.
  - IDLE -> CMD on synchronized SS fall.
  - CMD, on byte complete, by opcode:
    - 0x06 WREN: o_wel=1 at SS rise, only if exactly 8 bits were clocked; then IGNORE.
    - 0x04 WRDI: o_wel=0 at the same rule; then IGNORE.
    - 0x05: go to RDSR; transmit status {6'b0, o_wel, 1'b0} repeatedly (WIP is always 0).
    - 0x03: go to ADDR with mode READ.
    - 0x02: go to ADDR with mode WRITE.
    - Any other opcode: IGNORE.
  - ADDR, on byte complete: ptr <= byte[ADDR_BITS-1:0].
    - READ mode: go to RD_DATA.
    - WRITE mode: go to WR_DATA if o_wel=1, else IGNORE.
  - RD_DATA: each byte-boundary fall_p loads mem[ptr], then ptr <= ptr+1, wrapping modulo 2**ADDR_BITS.
  - WR_DATA: each complete byte writes mem[ptr] <= byte, then ptr <= ptr+1 with wrap. Writes are immediate; there is no page buffer.
  - IGNORE: MISO not driven; bytes still reported on o_rx_valid; no state change until SS rises.
- o_miso_oe: 1 only in RD_DATA and RDSR while SS is active. In other states o_miso=0.
- Simultaneous SS rise and byte-complete in the same cycle: the byte is processed first (memory write and o_rx_valid), then IDLE.
- A WREN frame with extra bits beyond 8 leaves o_wel unchanged.

Test Plan:
- WREN frame (0x06, SS high) -> o_wel=1. Then WRITE 0x02, 0x04, aa ff 00 55 c3 3c -> mem[4..9]=aa,ff,00,55,c3,3c; o_wel=0 after SS rise; six data o_rx_valid pulses plus two header pulses.
- READ 0x03, 0x04, then six 0x00 dummy bytes -> MISO bytes aa,ff,00,55,c3,3c, MSB valid before each byte's first SCLK rise; o_miso_oe=1 only during data.
- WRITE 0x02, 0x01, 0x77 with o_wel=0 -> mem[1] stays 0x00; following READ returns 0x00.
- With o_wel=1, WRITE at address 0x0F with data 11 22 -> mem[15]=0x11, mem[0]=0x22 (wrap). READ from 0x0F for 2 bytes returns 11,22.
- RDSR 0x05 after WREN -> MISO 0x02 on two consecutive bytes. Unknown opcode 0xAB -> o_miso_oe stays 0, memory unchanged.
- SS deasserted after 5 bits of a WRITE data byte -> no memory write, FSM IDLE. RST_N low mid-READ -> o_miso_oe=0 and o_wel=0 next cycle, memory cleared.

Source files
------------

// File: rtl/spi_eeprom_responder_if.sv
// SPI pins plus the side-band status of the EEPROM responder.
interface spi_eeprom_responder_if;
  logic       i_sclk;
  logic       i_ss_n;
  logic       i_mosi;
  logic       o_miso;
  logic       o_miso_oe;
  logic       o_wel;
  logic       o_rx_valid;
  logic [7:0] o_rx_byte;

  modport master (
    output i_sclk, i_ss_n, i_mosi,
    input  o_miso, o_miso_oe, o_wel, o_rx_valid, o_rx_byte
  );

  modport slave (
    input  i_sclk, i_ss_n, i_mosi,
    output o_miso, o_miso_oe, o_wel, o_rx_valid, o_rx_byte
  );
endinterface

// File: rtl/spi_eeprom_responder.sv
// Oversampled SPI mode-0 slave emulating the M95xxx WREN/WRDI/RDSR/READ/WRITE
// subset over a small register-array memory.
module spi_eeprom_responder #(
  parameter int ADDR_BITS   = 4,
  parameter int SYNC_STAGES = 2
) (
  input logic                    FCLK_CLK0,
  input logic                    RST_N,
  spi_eeprom_responder_if.slave  spi
);
  localparam int DEPTH = 2 ** ADDR_BITS;
  localparam logic [ADDR_BITS-1:0] PTR_ONE = 1;

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_WR_DATA, S_RD_DATA, S_RDSR, S_IGNORE
  } state_t;
  typedef enum logic [1:0] {P_NONE, P_WREN, P_WRDI} pend_t;

  logic [SYNC_STAGES-1:0] sclk_sync_q, ss_sync_q, mosi_sync_q;
  logic                   sclk_prev_q, ss_prev_q;
  state_t                 state_q, state_d;
  pend_t                  pend_q, pend_w;
  logic [2:0]             cnt_q;
  logic [7:0]             rx_sr_q, tx_sr_q, rx_byte_q;
  logic                   rx_valid_q, wel_q, mode_wr_q, wr_done_q;
  logic [ADDR_BITS-1:0]   ptr_q;
  logic [7:0]             mem_q [DEPTH];

  logic sclk_s, ss_s, mosi_s, rise_p, fall_p, ss_fall, ss_rise, ss_act;
  logic rx_bit, byte_done, cmd_done;
  logic [7:0] rx_byte_w, tx_next;

  assign sclk_s  = sclk_sync_q[SYNC_STAGES-1];
  assign ss_s    = ss_sync_q[SYNC_STAGES-1];
  assign mosi_s  = mosi_sync_q[SYNC_STAGES-1];
  assign rise_p  = sclk_s & ~sclk_prev_q;
  assign fall_p  = ~sclk_s & sclk_prev_q;
  assign ss_fall = ~ss_s & ss_prev_q;
  assign ss_rise = ss_s & ~ss_prev_q;
  // Gate on the previous SS sample so a final edge coinciding with SS rise still counts.
  assign ss_act    = ~ss_prev_q;
  assign rx_bit    = rise_p & ss_act;
  assign byte_done = rx_bit & (cnt_q == 3'd7);
  assign rx_byte_w = {rx_sr_q[6:0], mosi_s};
  assign cmd_done  = (state_q == S_CMD) & byte_done;
  assign tx_next   = (state_q == S_RDSR) ? {6'b0, wel_q, 1'b0} : mem_q[ptr_q];

  always_comb begin
    pend_w = pend_q;
    if (cmd_done)
      pend_w = (rx_byte_w == 8'h06) ? P_WREN :
               (rx_byte_w == 8'h04) ? P_WRDI : P_NONE;
    else if (rx_bit)
      pend_w = P_NONE;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (ss_fall) state_d = S_CMD;
      S_CMD: if (byte_done) begin
        case (rx_byte_w)
          8'h05:        state_d = S_RDSR;
          8'h03, 8'h02: state_d = S_ADDR;
          default:      state_d = S_IGNORE;
        endcase
      end
      S_ADDR: if (byte_done)
        state_d = !mode_wr_q ? S_RD_DATA : (wel_q ? S_WR_DATA : S_IGNORE);
      default: ;
    endcase
    if (ss_rise) state_d = S_IDLE;
  end

  always_ff @(posedge FCLK_CLK0) begin
    if (!RST_N) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge FCLK_CLK0) begin
    if (!RST_N) begin
      sclk_sync_q <= '0;
      ss_sync_q   <= '1;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      ss_prev_q   <= 1'b1;
      pend_q      <= P_NONE;
      cnt_q       <= '0;
      rx_sr_q     <= '0;
      tx_sr_q     <= '0;
      rx_byte_q   <= '0;
      rx_valid_q  <= 1'b0;
      wel_q       <= 1'b0;
      mode_wr_q   <= 1'b0;
      wr_done_q   <= 1'b0;
      ptr_q       <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi.i_sclk};
      ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], spi.i_ss_n};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi.i_mosi};
      sclk_prev_q <= sclk_s;
      ss_prev_q   <= ss_s;
      rx_valid_q  <= byte_done;
      pend_q      <= pend_w;
      if (byte_done) rx_byte_q <= rx_byte_w;
      if (rx_bit) begin
        rx_sr_q <= rx_byte_w;
        cnt_q   <= cnt_q + 3'd1;
      end
      if (cmd_done) mode_wr_q <= (rx_byte_w == 8'h02);
      if ((state_q == S_ADDR) && byte_done) ptr_q <= rx_byte_w[ADDR_BITS-1:0];
      if ((state_q == S_WR_DATA) && byte_done) begin
        mem_q[ptr_q] <= rx_byte_w;
        ptr_q        <= ptr_q + PTR_ONE;
        wr_done_q    <= 1'b1;
      end
      // Next byte is fetched on the fall that ends the previous byte.
      if (fall_p && ss_act) begin
        if (cnt_q == 3'd0) begin
          tx_sr_q <= tx_next;
          if (state_q == S_RD_DATA) ptr_q <= ptr_q + PTR_ONE;
        end else begin
          tx_sr_q <= {tx_sr_q[6:0], 1'b0};
        end
      end
      if (ss_rise) begin
        cnt_q     <= '0;
        pend_q    <= P_NONE;
        wr_done_q <= 1'b0;
        if (pend_w == P_WREN)      wel_q <= 1'b1;
        else if (pend_w == P_WRDI) wel_q <= 1'b0;
        if (wr_done_q || ((state_q == S_WR_DATA) && byte_done)) wel_q <= 1'b0;
      end
    end
  end

  assign spi.o_miso_oe  = ((state_q == S_RD_DATA) || (state_q == S_RDSR)) && !ss_s;
  assign spi.o_miso     = spi.o_miso_oe ? tx_sr_q[7] : 1'b0;
  assign spi.o_wel      = wel_q;
  assign spi.o_rx_valid = rx_valid_q;
  assign spi.o_rx_byte  = rx_byte_q;
endmodule

// File: tb/tb_spi_eeprom_responder.sv
// Directed bench: bit-banged SPI master frames against hand-computed results.
module tb_spi_eeprom_responder;
  localparam int HALF = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   rx_pulses = 0;
  int   base;

  logic [7:0] txq[$];
  logic [7:0] rxq[$];
  logic       oeq[$];

  spi_eeprom_responder_if bus ();

  spi_eeprom_responder #(.ADDR_BITS(4), .SYNC_STAGES(2)) dut (
    .FCLK_CLK0 (clk),
    .RST_N     (rst_n),
    .spi       (bus.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (bus.o_rx_valid === 1'b1) rx_pulses <= rx_pulses + 1;

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic xfer(input logic [7:0] tb, input int nb, output logic [7:0] rb, output logic oe);
    rb = 8'h00;
    oe = 1'b0;
    for (int i = 0; i < nb; i++) begin
      bus.i_mosi = tb[7-i];
      wait_cyc(HALF);
      rb[7-i] = bus.o_miso;
      if (i == 0) oe = bus.o_miso_oe;
      bus.i_sclk = 1'b1;
      wait_cyc(HALF);
      bus.i_sclk = 1'b0;
    end
  endtask

  // Sends txq, then extra_bits of extra_val, then deasserts SS.
  task automatic run_frame(input int extra_bits, input logic [7:0] extra_val);
    logic [7:0] rb;
    logic       oe;
    rxq.delete();
    oeq.delete();
    bus.i_ss_n = 1'b0;
    wait_cyc(HALF);
    foreach (txq[k]) begin
      xfer(txq[k], 8, rb, oe);
      rxq.push_back(rb);
      oeq.push_back(oe);
    end
    if (extra_bits > 0) xfer(extra_val, extra_bits, rb, oe);
    wait_cyc(HALF);
    bus.i_ss_n = 1'b1;
    wait_cyc(2 * HALF);
  endtask

  initial begin
    logic [7:0] rb;
    logic       oe;
    logic [7:0] exp_rd [6];
    exp_rd = '{8'haa, 8'hff, 8'h00, 8'h55, 8'hc3, 8'h3c};
    bus.i_sclk = 1'b0;
    bus.i_ss_n = 1'b1;
    bus.i_mosi = 1'b0;
    wait_cyc(4);
    check("rst_miso", bus.o_miso, 0);
    check("rst_oe", bus.o_miso_oe, 0);
    check("rst_wel", bus.o_wel, 0);
    check("rst_rxv", bus.o_rx_valid, 0);
    check("rst_rxbyte", bus.o_rx_byte, 8'h00);
    rst_n = 1'b1;
    wait_cyc(4);

    txq = '{8'h06}; run_frame(0, 0);
    check("wren_wel", bus.o_wel, 1);

    base = rx_pulses;
    txq = '{8'h02, 8'h04, 8'haa, 8'hff, 8'h00, 8'h55, 8'hc3, 8'h3c}; run_frame(0, 0);
    check("wr_wel_clr", bus.o_wel, 0);
    check("wr_pulses", rx_pulses - base, 8);
    check("wr_lastbyte", bus.o_rx_byte, 8'h3c);

    txq = '{8'h03, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}; run_frame(0, 0);
    check("rd_oe_cmd", oeq[0], 0);
    check("rd_oe_addr", oeq[1], 0);
    for (int k = 0; k < 6; k++) begin
      check($sformatf("rd_byte%0d", k), rxq[k+2], exp_rd[k]);
      check($sformatf("rd_oe%0d", k), oeq[k+2], 1);
    end

    txq = '{8'h02, 8'h01, 8'h77}; run_frame(0, 0);
    txq = '{8'h03, 8'h01, 8'h00}; run_frame(0, 0);
    check("nowel_mem1", rxq[2], 8'h00);

    txq = '{8'h06}; run_frame(0, 0);
    txq = '{8'h02, 8'h0f, 8'h11, 8'h22}; run_frame(0, 0);
    txq = '{8'h03, 8'h0f, 8'h00, 8'h00}; run_frame(0, 0);
    check("wrap_mem15", rxq[2], 8'h11);
    check("wrap_mem0", rxq[3], 8'h22);

    txq = '{8'h06}; run_frame(0, 0);
    txq = '{8'h05, 8'h00, 8'h00}; run_frame(0, 0);
    check("rdsr_b0", rxq[1], 8'h02);
    check("rdsr_b1", rxq[2], 8'h02);
    check("rdsr_oe", oeq[1], 1);
    txq = '{8'h04}; run_frame(0, 0);
    check("wrdi_wel", bus.o_wel, 0);

    txq = '{8'hab, 8'h00, 8'h00}; run_frame(0, 0);
    check("unk_oe1", oeq[1], 0);
    check("unk_oe2", oeq[2], 0);
    txq = '{8'h03, 8'h04, 8'h00}; run_frame(0, 0);
    check("unk_mem4", rxq[2], 8'haa);

    txq = '{8'h06}; run_frame(1, 8'h80);
    check("wren9_wel", bus.o_wel, 0);

    txq = '{8'h06}; run_frame(0, 0);
    txq = '{8'h02, 8'h05}; run_frame(5, 8'h12);
    check("part_wel", bus.o_wel, 1);
    txq = '{8'h03, 8'h05, 8'h00}; run_frame(0, 0);
    check("part_mem5", rxq[2], 8'hff);

    bus.i_ss_n = 1'b0;
    wait_cyc(HALF);
    xfer(8'h03, 8, rb, oe);
    xfer(8'h04, 8, rb, oe);
    xfer(8'h00, 8, rb, oe);
    check("mid_oe_pre", bus.o_miso_oe, 1);
    rst_n = 1'b0;
    wait_cyc(1);
    check("mid_rst_oe", bus.o_miso_oe, 0);
    check("mid_rst_wel", bus.o_wel, 0);
    wait_cyc(3);
    rst_n = 1'b1;
    wait_cyc(HALF);
    bus.i_ss_n = 1'b1;
    wait_cyc(2 * HALF);
    txq = '{8'h03, 8'h04, 8'h00}; run_frame(0, 0);
    check("rst_mem4", rxq[2], 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
